// File: rtl/btn_pkg.sv
// Shared types and helpers for the button step controller and related
// button/switch input logic.
//   state_t   : step FSM states (2-bit encoding)
//   cnt_width : width of a counter that must reach max(a, b)-1
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-stage synchroniser for asynchronous level inputs.
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous input level
//   q     : synchronised level, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s0 <= d;
      q  <= s0;
    end
  end

endmodule

// File: rtl/btn_step_ctrl.sv
// Turns the debounced button level into CPU single-step tokens, one per
// press plus optional auto-repeat while held, delivered on valid/ready.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   btn_level   : debounced button level, asynchronous to clk
//   step_ready  : consumer accepts the pending token this cycle
//   clr_overrun : one-cycle pulse clearing overrun
//   step_valid  : step token pending
//   held        : high while in the auto-repeat phase
//   press_cnt   : count of accepted tokens, wraps modulo 2^CNT_W
//   overrun     : sticky, a token was dropped while one was still pending
module btn_step_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          AUTO_REPEAT   = 1'b1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_level,
  input  logic             step_ready,
  input  logic             clr_overrun,
  output logic             step_valid,
  output logic             held,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overrun
);

  localparam int unsigned CW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  logic          lvl;
  logic          prev;
  logic [1:0]    warm;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rise;
  logic          emit;
  logic          xfer;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_level),
    .q     (lvl)
  );

  always_comb begin
    rise     = lvl & ~prev;
    xfer     = step_valid & step_ready;
    state_nx = state;
    cnt_nx   = cnt;
    emit     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          emit     = 1'b1;
          state_nx = HOLD;
          cnt_nx   = '0;
        end
      end
      HOLD: begin
        if (!lvl) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == HOLD_LAST) begin
          if (AUTO_REPEAT) begin
            emit     = 1'b1;
            state_nx = RPT;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RPT: begin
        if (!lvl) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == REPEAT_LAST) begin
          emit   = 1'b1;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      prev       <= 1'b1;
      warm       <= '0;
      step_valid <= 1'b0;
      held       <= 1'b0;
      press_cnt  <= '0;
      overrun    <= 1'b0;
    end else begin
      // The synchroniser emits reset zeros for two edges after reset; prev
      // is pinned high until real samples arrive so a button held through
      // reset is not mistaken for a fresh press.
      warm  <= {warm[0], 1'b1};
      prev  <= warm[1] ? lvl : 1'b1;
      state <= state_nx;
      cnt   <= cnt_nx;
      held  <= (state_nx == RPT);

      if (xfer) begin
        press_cnt <= press_cnt + 1'b1;
      end

      if (emit) begin
        step_valid <= 1'b1;
      end else if (xfer) begin
        step_valid <= 1'b0;
      end

      if (emit && step_valid && !step_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
